// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one sample per handshake, taps walked serially through
// a single shared multiply-accumulate, result presented with a one-cycle strobe.
module fir_mac_sequencer #(
  parameter int WORD_WIDTH = 16,
  parameter int TAPS       = 56,
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_WIDTH = $clog2(TAPS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [WORD_WIDTH-1:0] x,
  input  logic                         x_valid,
  output logic                         x_ready,
  input  logic                         coef_we,
  input  logic        [ADDR_WIDTH-1:0] coef_addr,
  input  logic signed [WORD_WIDTH-1:0] coef_data,
  output logic                         busy,
  output logic signed [ACC_WIDTH-1:0]  y,
  output logic                         y_valid
);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_TAP = ADDR_WIDTH'(TAPS - 1);
  localparam logic [ADDR_WIDTH-1:0] TAPS_MOD = ADDR_WIDTH'(TAPS);

  state_t                         state_q, state_d;
  logic        [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic        [ADDR_WIDTH-1:0]   k_q, k_d;
  logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0]    y_q, y_d;
  logic                           y_valid_q, y_valid_d;
  logic signed [WORD_WIDTH-1:0]   hist_q [TAPS];
  logic signed [WORD_WIDTH-1:0]   coef_q [TAPS];

  logic                           hist_we, coef_wr, coef_addr_ok;
  logic        [ADDR_WIDTH-1:0]   ptr_inc, rd_idx;
  logic signed [2*WORD_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    prod_ext, acc_sum;

  // Modulo-TAPS subtraction; the wrapped branch stays exact in ADDR_WIDTH bits
  // because the true result is always below TAPS.
  assign rd_idx       = (wr_ptr_q >= k_q) ? wr_ptr_q - k_q : wr_ptr_q + TAPS_MOD - k_q;
  assign ptr_inc      = (wr_ptr_q == LAST_TAP) ? '0 : wr_ptr_q + 1'b1;
  assign prod         = coef_q[k_q] * hist_q[rd_idx];
  assign prod_ext     = ACC_WIDTH'(prod);
  assign acc_sum      = acc_q + prod_ext;
  assign coef_addr_ok = 32'(coef_addr) < TAPS;

  assign x_ready = !rst && (state_q == IDLE) && !coef_we;
  assign busy    = !rst && (state_q != IDLE);
  assign y       = y_q;
  assign y_valid = y_valid_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    k_d       = k_q;
    acc_d     = acc_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    hist_we   = 1'b0;
    coef_wr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (coef_we) begin
          coef_wr = coef_addr_ok;
        end else if (x_valid) begin
          wr_ptr_d = ptr_inc;
          hist_we  = 1'b1;
          acc_d    = '0;
          k_d      = '0;
          state_d  = MAC;
        end
      end
      MAC: begin
        acc_d = acc_sum;
        if (k_q == LAST_TAP) begin
          y_d       = acc_sum;
          y_valid_d = 1'b1;
          state_d   = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register sees
    // the pre-edge values of the others regardless of statement order.
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      // NOTE: both banks are flop arrays, not RAM, because reset must zero
      // the history and coefficients for the first outputs to be correct.
      for (int i = 0; i < TAPS; i++) begin
        hist_q[i] <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      if (hist_we) hist_q[ptr_inc]   <= x;
      if (coef_wr) coef_q[coef_addr] <= coef_data;
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: a convolution model pushes expected results on
// each acceptance; a monitor pops and compares them on every y_valid strobe.
module tb_fir_mac_sequencer;

  localparam int WW   = 16;
  localparam int TAPS = 56;
  localparam int AW   = 32;
  localparam int ADW  = $clog2(TAPS);

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic signed [WW-1:0]  x = '0;
  logic                  x_valid = 1'b0;
  logic                  x_ready;
  logic                  coef_we = 1'b0;
  logic        [ADW-1:0] coef_addr = '0;
  logic signed [WW-1:0]  coef_data = '0;
  logic                  busy;
  logic signed [AW-1:0]  y;
  logic                  y_valid;

  fir_mac_sequencer #(.WORD_WIDTH(WW), .TAPS(TAPS), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .x_ready(x_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .busy(busy), .y(y), .y_valid(y_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int yv_count  = 0;
  logic signed [AW-1:0] last_y = '0;
  logic signed [AW-1:0] sb_exp;
  logic signed [AW-1:0] sb_q[$];
  logic signed [WW-1:0] m_hist[TAPS];
  logic signed [WW-1:0] m_coef[TAPS];
  int m_ptr = 0;

  // Scoreboard monitor: every strobe must match the oldest outstanding result.
  always @(negedge clk) begin
    if (y_valid === 1'b1) begin
      yv_count++;
      last_y = y;
      total_cnt++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_y_valid: got y=%0d with no result outstanding", y);
      end else begin
        sb_exp = sb_q.pop_front();
        if (y !== sb_exp) $display("FAIL scoreboard_y: got %0d expected %0d", y, sb_exp);
        else pass_cnt++;
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < TAPS; i++) begin
      m_hist[i] = '0;
      m_coef[i] = '0;
    end
    m_ptr = 0;
    sb_q.delete();
  endtask

  task automatic model_accept(input logic signed [WW-1:0] xv);
    logic signed [AW-1:0] s;
    int idx;
    m_ptr = (m_ptr == TAPS - 1) ? 0 : m_ptr + 1;
    m_hist[m_ptr] = xv;
    s = '0;
    for (int k = 0; k < TAPS; k++) begin
      idx = (m_ptr - k + TAPS) % TAPS;
      s = s + int'(m_coef[k]) * int'(m_hist[idx]);
    end
    sb_q.push_back(s);
  endtask

  task automatic write_coef(input int addr, input logic signed [WW-1:0] data);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = ADW'(addr);
    coef_data = data;
    m_coef[addr] = data;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  // Offers one sample and returns at the negedge right after its acceptance.
  task automatic send_sample(input logic signed [WW-1:0] xv);
    int budget;
    @(negedge clk);
    x = xv;
    x_valid = 1'b1;
    #1;
    budget = 0;
    while (x_ready !== 1'b1 && budget < 200) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (x_ready !== 1'b1) begin
      total_cnt++;
      $display("FAIL accept_timeout: x_ready stayed %b for %0d cycles", x_ready, budget);
      x_valid = 1'b0;
      return;
    end
    model_accept(xv);
    @(negedge clk);
    x_valid = 1'b0;
  endtask

  task automatic wait_result();
    int budget = 0;
    while (sb_q.size() != 0 && budget < 300) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (sb_q.size() != 0) begin
      total_cnt++;
      $display("FAIL result_timeout: %0d results still outstanding", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic do_reset(input int cycles, input logic xv);
    @(negedge clk);
    rst = 1'b1;
    x_valid = xv;
    x = 16'sh1234;
    coef_we = 1'b0;
    model_clear();
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      #1;
      total_cnt++;
      if ({x_ready, busy, y_valid} !== 3'b000 || y !== '0)
        $display("FAIL reset_outputs: got x_ready=%b busy=%b y_valid=%b y=%0d expected 0 0 0 0",
                 x_ready, busy, y_valid, y);
      else pass_cnt++;
    end
    rst = 1'b0;
    x_valid = 1'b0;
    #1;
    total_cnt++;
    if (x_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_release: got x_ready=%b busy=%b expected 1 0", x_ready, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    do_reset(3, 1'b0);
    do_reset(3, 1'b1);
  endtask

  task automatic test_impulse();
    logic signed [AW-1:0] expv[5] = '{32'sd96859252, 32'sd0, -32'sd404934586, 32'sd0, 32'sd0};
    logic signed [WW-1:0] xs[5]   = '{16'sd32767, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    do_reset(1, 1'b0);
    write_coef(0, 16'sd2956);
    write_coef(2, -16'sd12358);
    for (int i = 0; i < 5; i++) begin
      send_sample(xs[i]);
      if (i == 0) begin
        #1;
        total_cnt++;
        if (busy !== 1'b1 || x_ready !== 1'b0)
          $display("FAIL mac_flags: got busy=%b x_ready=%b expected 1 0", busy, x_ready);
        else pass_cnt++;
      end
      wait_result();
      total_cnt++;
      if (last_y !== expv[i]) $display("FAIL impulse_%0d: got %0d expected %0d", i, last_y, expv[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic signed [WW-1:0] vals[4] = '{16'sd1000, -16'sd2000, 16'sd30000, -16'sd32768};
    int n_acc = 0, last_acc = 0, yv_seen = 0, budget = 0, ae;
    logic prev_yv = 1'b0;
    do_reset(1, 1'b0);
    write_coef(0, 16'sd3);
    write_coef(1, -16'sd5);
    write_coef(55, 16'sd7);
    @(negedge clk);
    x = vals[0];
    x_valid = 1'b1;
    while (budget < 400 && !(n_acc == 4 && yv_seen == 4)) begin
      #1;
      if (y_valid === 1'b1) begin
        yv_seen++;
        total_cnt++;
        if (cyc - last_acc != 56 || prev_yv)
          $display("FAIL latency: got %0d edges (prev strobe %b) expected 56 (0)", cyc - last_acc, prev_yv);
        else pass_cnt++;
      end
      prev_yv = (y_valid === 1'b1);
      if (x_valid && x_ready === 1'b1) begin
        ae = cyc + 1;
        if (n_acc > 0) begin
          total_cnt++;
          if (ae - last_acc != 58) $display("FAIL throughput: got %0d edges apart expected 58", ae - last_acc);
          else pass_cnt++;
        end
        model_accept(x);
        last_acc = ae;
        n_acc++;
      end
      @(negedge clk);
      budget++;
      if (n_acc < 4) x = vals[n_acc];
      else x_valid = 1'b0;
    end
    x_valid = 1'b0;
    total_cnt++;
    if (n_acc != 4 || yv_seen != 4)
      $display("FAIL b2b_count: got %0d accepts %0d results expected 4 4", n_acc, yv_seen);
    else pass_cnt++;
    wait_result();
  endtask

  task automatic test_write_priority();
    int budget = 0;
    do_reset(1, 1'b0);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = '0; coef_data = 16'sd100;
    x = 16'sd321; x_valid = 1'b1;
    m_coef[0] = 16'sd100;
    #1;
    total_cnt++;
    if (x_ready !== 1'b0) $display("FAIL write_wins: got x_ready=%b expected 0", x_ready);
    else pass_cnt++;
    @(negedge clk);
    coef_we = 1'b0;
    #1;
    total_cnt++;
    if (x_ready !== 1'b1) $display("FAIL sample_next_cycle: got x_ready=%b expected 1", x_ready);
    else pass_cnt++;
    model_accept(16'sd321);
    @(negedge clk);
    x_valid = 1'b0;
    coef_we = 1'b1; coef_addr = '0; coef_data = 16'sd7777;
    #1;
    total_cnt++;
    if (x_ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL mac_locked_flags: got x_ready=%b busy=%b expected 0 1", x_ready, busy);
    else pass_cnt++;
    @(negedge clk);
    coef_we = 1'b0;
    while (y_valid !== 1'b1 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    coef_we = 1'b1; coef_addr = ADW'(1); coef_data = 16'sd5555;
    @(negedge clk);
    coef_we = 1'b0;
    wait_result();
    total_cnt++;
    if (last_y !== 32'sd32100) $display("FAIL priority_result: got %0d expected 32100", last_y);
    else pass_cnt++;
    send_sample(-16'sd2000);
    wait_result();
    total_cnt++;
    if (last_y !== -32'sd200000) $display("FAIL locked_bank: got %0d expected -200000", last_y);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [AW-1:0] ev;
    int n;
    do_reset(1, 1'b0);
    for (int i = 0; i < TAPS; i++) write_coef(i, -16'sd32768);
    for (int i = 0; i < 60; i++) begin
      send_sample(-16'sd32768);
      wait_result();
      n = (i + 1 < TAPS) ? i + 1 : TAPS;
      ev = 32'(n) << 30;
      total_cnt++;
      if (last_y !== $signed(ev)) $display("FAIL wrap_%0d: got %0d expected %0d", i, last_y, $signed(ev));
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_sweep();
    int yv_before;
    send_sample(-16'sd32768);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++;
    if (x_ready !== 1'b1 || busy !== 1'b0 || y_valid !== 1'b0 || y !== '0)
      $display("FAIL midsweep_reset: got x_ready=%b busy=%b y_valid=%b y=%0d expected 1 0 0 0",
               x_ready, busy, y_valid, y);
    else pass_cnt++;
    yv_before = yv_count;
    repeat (70) @(negedge clk);
    #1;
    total_cnt++;
    if (yv_count != yv_before || y !== '0)
      $display("FAIL dropped_result: got %0d strobes y=%0d expected 0 strobes y=0", yv_count - yv_before, y);
    else pass_cnt++;
    write_coef(0, 16'sd1000);
    write_coef(5, 16'sd3);
    send_sample(16'sd1234);
    wait_result();
    total_cnt++;
    if (last_y !== 32'sd1234000) $display("FAIL cleared_history: got %0d expected 1234000", last_y);
    else pass_cnt++;
  endtask

  initial begin
    model_clear();
    repeat (2) @(negedge clk);
    test_reset();
    test_impulse();
    test_back_to_back();
    test_write_priority();
    test_wrap();
    test_reset_mid_sweep();
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Time-multiplexed FIR controller. It accepts one input sample per handshake, stores it in a circular history buffer, and walks all taps through a single shared multiply-accumulate unit. It presents the filtered result with a one-cycle valid strobe. It replaces the fully parallel tap array where DSP resources are scarce and the sample rate is at most clk/(TAPS+2), and it owns a run-time writable coefficient bank.

## Interface
- WORD_WIDTH, 16: sample and coefficient width, signed Q1.15.
- TAPS, 56: number of taps (filter order + 1), ≥ 2.
- ACC_WIDTH, 32: accumulator and output width.
- ADDR_WIDTH, $clog2(TAPS): coefficient address width.
- clk, input, 1: single clock; all logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- x, input, WORD_WIDTH signed: input sample.
- x_valid, input, 1: sample offered.
- x_ready, output, 1: the sequencer can accept a sample. A transfer occurs when x_valid && x_ready at a rising edge.
- coef_we, input, 1: coefficient write strobe.
- coef_addr, input, ADDR_WIDTH: tap index, 0..TAPS-1.
- coef_data, input, WORD_WIDTH signed: coefficient value h[coef_addr].
- busy, output, 1: a MAC sweep or result cycle is in progress.
- y, output, ACC_WIDTH signed: last filter result. Holds its value between results.
- y_valid, output, 1: one-cycle strobe marking a new y.

## Operation
- Storage:
  - hist[0..TAPS-1]: sample history, WORD_WIDTH each.
  - coef[0..TAPS-1]: coefficient bank.
  - wr_ptr: newest-sample index, 0..TAPS-1.
  - k: tap counter.
  - acc: ACC_WIDTH accumulator.
- The FSM has three states: IDLE, MAC and DONE.
- IDLE:
  - x_ready = !coef_we; busy = 0.
  - If coef_we is asserted, coef[coef_addr] <= coef_data.
  - If coef_we and x_valid are asserted together, the coefficient write wins and the sample is not accepted.
  - On transfer:
    - wr_ptr advances: wr_ptr <= (wr_ptr == TAPS-1) ? 0 : wr_ptr+1.
    - hist[new wr_ptr] <= x.
    - acc <= 0, k <= 0.
    - Next state is MAC.
- MAC, one tap per cycle:
  - acc <= acc + coef[k] * hist[(wr_ptr - k) mod TAPS].
  - The product is the full 2*WORD_WIDTH signed value, sign-extended (or truncated) to ACC_WIDTH.
  - The sum wraps modulo 2^ACC_WIDTH. There is no saturation.
  - On the k == TAPS-1 edge:
    - y <= acc + last product.
    - y_valid <= 1.
    - Next state is DONE.
  - Otherwise k <= k+1.
  - x_ready = 0 and busy = 1.
  - coef_we is ignored; the bank is unchanged.
- DONE:
  - y_valid = 1, x_ready = 0, busy = 1; coef_we is ignored.
  - Next state is IDLE and y_valid <= 0.
- Result: y = Σ_{k=0}^{TAPS-1} h[k]·x[n-k]. Samples before the first accepted sample count as 0.
- Reset (rst = 1 at an edge) applies from any state, including mid-sweep:
  - State goes to IDLE; any in-flight result is dropped and no y_valid follows.
  - hist, coef, wr_ptr, k, acc, y and y_valid are all cleared to 0.
  - While rst is high: x_ready = 0 and busy = 0.

## Timing
- Reset values: x_ready 0 while rst is high, then 1 in the first IDLE cycle. busy 0, y 0, y_valid 0.
- Latency: a sample accepted at edge E0 produces y and y_valid at edge E0+TAPS, i.e. E56 at the default.
- y_valid is high for exactly one cycle. x_ready returns high after edge E0+TAPS+1.
- Throughput: back-to-back acceptances are exactly TAPS+2 edges apart (58 at the default).
- x_ready depends combinationally on coef_we and state only. It never depends on x_valid.
- A coefficient written at edge E is used by any sweep accepted at E+1 or later.

## Test plan
- Reset behaviour: assert rst for 3 cycles, with and without x_valid high. During reset x_ready = 0, busy = 0, y = 0, y_valid = 0. The first cycle after reset has x_ready = 1.
- Impulse response:
  - Load h[0] = 2956 and h[2] = -12358, all other taps 0.
  - Send 32767, then zeros.
  - Successive results are 96859252, 0, -404934586, 0, ...
- Throughput: hold x_valid = 1 continuously. Acceptances land exactly 58 edges apart, and each y_valid fires 56 edges after its acceptance.
- Write priority and locking:
  - Assert coef_we (h[0] = 100) together with x_valid in IDLE: the write lands, x_ready = 0, and the sample is taken one cycle later.
  - A coef_we pulse during MAC or DONE leaves the bank unchanged; verify through a subsequent impulse result.
- Wrap arithmetic:
  - Load all h = -32768 and feed x = -32768 repeatedly.
  - Results are 1073741824, -2147483648, -1073741824, 0, and so on cyclically.
  - After 56 or more samples the result is 0, which also exercises the wr_ptr wrap.
- Reset mid-sweep:
  - Assert rst for one cycle at k = 20.
  - No y_valid follows and y = 0.
  - The next impulse with h[0] = 1000 (reloaded after reset) yields exactly 1000·x, confirming the history was cleared.
